// File: rtl/image_scaler_cfg_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : image_scaler_cfg_ctrl
// Brief    : Serial-divider scale-factor sequencer; swaps the new configuration
//            into the active registers on a frame boundary.
//            Optional feature macro: SCALER_CFG_VALIDATE_EN.
// Revision : 1.0
//==============================================================================
module image_scaler_cfg_ctrl #(
   parameter int G_RES_WIDTH  = 13,
   parameter int G_SF_WIDTH   = 16,
   parameter int G_FRAC_BITS  = 10,
   parameter int G_RST_CYCLES = 16,
   parameter int G_DEF_HIN    = 960,
   parameter int G_DEF_VIN    = 540,
   parameter int G_DEF_HOUT   = 1280,
   parameter int G_DEF_VOUT   = 720,
   parameter int G_DEF_SFH    = 767,
   parameter int G_DEF_SFV    = 766
) (
   input  logic                   SYS_CLK_I,
   input  logic                   RESET_I,
   input  logic                   CFG_WE_I,
   input  logic [G_RES_WIDTH-1:0] CFG_HIN_I,
   input  logic [G_RES_WIDTH-1:0] CFG_VIN_I,
   input  logic [G_RES_WIDTH-1:0] CFG_HOUT_I,
   input  logic [G_RES_WIDTH-1:0] CFG_VOUT_I,
   input  logic                   FRAME_START_I,
   output logic                   CFG_BUSY_O,
   output logic                   CFG_DONE_O,
   output logic                   CFG_ERR_O,
   output logic [G_RES_WIDTH-1:0] HORZ_RES_IN_O,
   output logic [G_RES_WIDTH-1:0] VERT_RES_IN_O,
   output logic [G_RES_WIDTH-1:0] HORZ_RES_OUT_O,
   output logic [G_RES_WIDTH-1:0] VERT_RES_OUT_O,
   output logic [G_SF_WIDTH-1:0]  SCALE_FACTOR_HORZ_O,
   output logic [G_SF_WIDTH-1:0]  SCALE_FACTOR_VERT_O,
   output logic                   SCALER_RESETN_O
);

   localparam int NUM_W   = G_RES_WIDTH + G_FRAC_BITS;
   localparam int CNT_MAX = (NUM_W > G_RST_CYCLES) ? NUM_W : G_RST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DIV_H = 3'd1;
   localparam logic [2:0] S_DIV_V = 3'd2;
   localparam logic [2:0] S_PEND  = 3'd3;
   localparam logic [2:0] S_APPLY = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   logic [2:0]             state, next_state;
   logic [CNT_W-1:0]       cnt;
   logic [G_RES_WIDTH-1:0] sh_hin, sh_vin, sh_hout, sh_vout;
   logic [G_SF_WIDTH-1:0]  sf_h_new, sf_v_new;
   logic [NUM_W-1:0]       quo;
   logic [G_RES_WIDTH-1:0] rem;

   logic [G_RES_WIDTH-1:0] divisor;
   logic [G_RES_WIDTH:0]   trial;
   logic [G_RES_WIDTH-1:0] diff;
   logic                   ge;
   logic [G_RES_WIDTH-1:0] rem_nx;
   logic [NUM_W-1:0]       q_final;
   logic                   sat;
   logic [G_SF_WIDTH-1:0]  sf_final;
   logic                   last_bit;
   logic                   hold_done;

`ifdef SCALER_CFG_VALIDATE_EN
   logic range_bad;
   logic sat_h;
   logic range_fail_now;
   assign range_fail_now = (CFG_HIN_I < G_RES_WIDTH'(2)) || (CFG_VIN_I < G_RES_WIDTH'(2)) ||
                           (CFG_HOUT_I == '0) || (CFG_VOUT_I == '0);
`else
   assign CFG_ERR_O = 1'b0;
`endif

   // An input of 0 yields a zero numerator rather than a wrapped (IN-1).
   function automatic logic [NUM_W-1:0] numer(input logic [G_RES_WIDTH-1:0] v);
      if (v == '0) return '0;
      return {v - G_RES_WIDTH'(1), {G_FRAC_BITS{1'b0}}};
   endfunction

   // One restoring-division step; the numerator shifts out of quo as quotient bits shift in.
   assign divisor   = (state == S_DIV_V) ? sh_vout : sh_hout;
   assign trial     = {rem, quo[NUM_W-1]};
   assign ge        = trial >= {1'b0, divisor};
   assign diff      = trial[G_RES_WIDTH-1:0] - divisor;
   assign rem_nx    = ge ? diff : trial[G_RES_WIDTH-1:0];
   assign q_final   = {quo[NUM_W-2:0], ge};
   assign sat       = |q_final[NUM_W-1:G_SF_WIDTH];
   assign sf_final  = sat ? '1 : q_final[G_SF_WIDTH-1:0];
   assign last_bit  = (cnt == CNT_W'(NUM_W - 1));
   assign hold_done = (cnt == CNT_W'(G_RST_CYCLES - 1));

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (CFG_WE_I) next_state = S_DIV_H;
         S_DIV_H: begin
            if (last_bit) next_state = S_DIV_V;
`ifdef SCALER_CFG_VALIDATE_EN
            if (range_bad) next_state = S_IDLE;
`endif
         end
         S_DIV_V: begin
            if (last_bit) next_state = S_PEND;
`ifdef SCALER_CFG_VALIDATE_EN
            if (last_bit && (sat_h || sat)) next_state = S_IDLE;
`endif
         end
         S_PEND:  if (FRAME_START_I) next_state = S_APPLY;
         S_APPLY: next_state = S_HOLD;
         S_HOLD:  if (hold_done) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK_I) begin
      if (RESET_I) begin
         state               <= S_IDLE;
         cnt                 <= '0;
         sh_hin              <= '0;
         sh_vin              <= '0;
         sh_hout             <= '0;
         sh_vout             <= '0;
         sf_h_new            <= '0;
         sf_v_new            <= '0;
         quo                 <= '0;
         rem                 <= '0;
         CFG_BUSY_O          <= 1'b0;
         CFG_DONE_O          <= 1'b0;
         SCALER_RESETN_O     <= 1'b0;
         HORZ_RES_IN_O       <= G_RES_WIDTH'(G_DEF_HIN);
         VERT_RES_IN_O       <= G_RES_WIDTH'(G_DEF_VIN);
         HORZ_RES_OUT_O      <= G_RES_WIDTH'(G_DEF_HOUT);
         VERT_RES_OUT_O      <= G_RES_WIDTH'(G_DEF_VOUT);
         SCALE_FACTOR_HORZ_O <= G_SF_WIDTH'(G_DEF_SFH);
         SCALE_FACTOR_VERT_O <= G_SF_WIDTH'(G_DEF_SFV);
`ifdef SCALER_CFG_VALIDATE_EN
         CFG_ERR_O           <= 1'b0;
         range_bad           <= 1'b0;
         sat_h               <= 1'b0;
`endif
      end else begin
         state           <= next_state;
         CFG_BUSY_O      <= (next_state != S_IDLE);
         CFG_DONE_O      <= (next_state == S_APPLY);
         SCALER_RESETN_O <= !((next_state == S_APPLY) || (next_state == S_HOLD));
         case (state)
            S_IDLE: begin
               if (CFG_WE_I) begin
                  sh_hin  <= CFG_HIN_I;
                  sh_vin  <= CFG_VIN_I;
                  sh_hout <= CFG_HOUT_I;
                  sh_vout <= CFG_VOUT_I;
                  quo     <= numer(CFG_HIN_I);
                  rem     <= '0;
                  cnt     <= '0;
`ifdef SCALER_CFG_VALIDATE_EN
                  CFG_ERR_O <= 1'b0;
                  range_bad <= range_fail_now;
`endif
               end
            end
            S_DIV_H: begin
               quo <= q_final;
               rem <= rem_nx;
               cnt <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sf_h_new <= sf_final;
                  quo      <= numer(sh_vin);
                  rem      <= '0;
                  cnt      <= '0;
`ifdef SCALER_CFG_VALIDATE_EN
                  sat_h    <= sat;
`endif
               end
`ifdef SCALER_CFG_VALIDATE_EN
               if (range_bad) CFG_ERR_O <= 1'b1;
`endif
            end
            S_DIV_V: begin
               quo <= q_final;
               rem <= rem_nx;
               cnt <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sf_v_new <= sf_final;
`ifdef SCALER_CFG_VALIDATE_EN
                  if (sat_h || sat) CFG_ERR_O <= 1'b1;
`endif
               end
            end
            S_APPLY: begin
               HORZ_RES_IN_O       <= sh_hin;
               VERT_RES_IN_O       <= sh_vin;
               HORZ_RES_OUT_O      <= sh_hout;
               VERT_RES_OUT_O      <= sh_vout;
               SCALE_FACTOR_HORZ_O <= sf_h_new;
               SCALE_FACTOR_VERT_O <= sf_v_new;
               cnt                 <= '0;
            end
            S_HOLD:  cnt <= cnt + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_image_scaler_cfg_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_image_scaler_cfg_ctrl
// Brief    : Randomized and directed bench for image_scaler_cfg_ctrl against a
//            timestamp-based behavioural model. Honours SCALER_CFG_VALIDATE_EN.
// Revision : 1.0
//==============================================================================
module tb_image_scaler_cfg_ctrl;

   localparam int G = 16;

   logic        clk = 1'b0;
   logic        rst, we, fs;
   logic [12:0] hin, vin, hout, vout;
   logic        busy, done, err, resetn;
   logic [12:0] o_hin, o_vin, o_hout, o_vout;
   logic [15:0] o_sfh, o_sfv;

   always #5 clk = ~clk;

   image_scaler_cfg_ctrl dut (
      .SYS_CLK_I           (clk),
      .RESET_I             (rst),
      .CFG_WE_I            (we),
      .CFG_HIN_I           (hin),
      .CFG_VIN_I           (vin),
      .CFG_HOUT_I          (hout),
      .CFG_VOUT_I          (vout),
      .FRAME_START_I       (fs),
      .CFG_BUSY_O          (busy),
      .CFG_DONE_O          (done),
      .CFG_ERR_O           (err),
      .HORZ_RES_IN_O       (o_hin),
      .VERT_RES_IN_O       (o_vin),
      .HORZ_RES_OUT_O      (o_hout),
      .VERT_RES_OUT_O      (o_vout),
      .SCALE_FACTOR_HORZ_O (o_sfh),
      .SCALE_FACTOR_VERT_O (o_sfv),
      .SCALER_RESETN_O     (resetn)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Unclamped quotient; a zero divisor behaves as an all-ones 23-bit result.
   function automatic int raw_sf(input int in_r, input int out_r);
      longint num;
      if (out_r == 0) return 32'h7F_FFFF;
      num = (in_r == 0) ? 0 : longint'(in_r - 1) * 1024;
      return int'(num / out_r);
   endfunction

   function automatic int clamp_sf(input int q);
      return (q > 65535) ? 65535 : q;
   endfunction

   // Model: a request is described by its accept edge and frame-start edge.
   int e = 0;
   bit model_valid = 0;
   bit has_req = 0;
   int req_t = 0, fs_t = -1, kind = 0;
   int p_hin, p_vin, p_hout, p_vout, p_sfh, p_sfv;
   int x_hin, x_vin, x_hout, x_vout, x_sfh, x_sfv;
   bit x_busy, x_done, x_resetn, x_err;

   task automatic model_step();
      int qh, qv;
      e++;
      model_valid = 1;
      if (rst) begin
         has_req = 0; fs_t = -1;
         x_hin = 960; x_vin = 540; x_hout = 1280; x_vout = 720;
         x_sfh = 767; x_sfv = 766;
         x_busy = 0; x_done = 0; x_resetn = 0; x_err = 0;
         return;
      end
      if (has_req) begin
         if (kind == 0 && fs_t >= 0 && e >= fs_t + G + 2) has_req = 0;
         else if (kind == 1 && e >= req_t + 2) has_req = 0;
         else if (kind == 2 && e >= req_t + 47) has_req = 0;
      end
      if (!has_req && we) begin
         has_req = 1; req_t = e; fs_t = -1; kind = 0;
         p_hin = hin; p_vin = vin; p_hout = hout; p_vout = vout;
         qh = raw_sf(p_hin, p_hout);
         qv = raw_sf(p_vin, p_vout);
         p_sfh = clamp_sf(qh);
         p_sfv = clamp_sf(qv);
`ifdef SCALER_CFG_VALIDATE_EN
         x_err = 0;
         if (p_hin < 2 || p_vin < 2 || p_hout < 1 || p_vout < 1) kind = 1;
         else if (qh > 65535 || qv > 65535) kind = 2;
`endif
      end else if (has_req && kind == 0 && fs_t < 0 && fs && e >= req_t + 47) begin
         fs_t = e;
      end
      if (!has_req) x_busy = 0;
      else if (kind == 0) x_busy = (fs_t < 0) || (e <= fs_t + G);
      else if (kind == 1) x_busy = (e == req_t);
      else x_busy = (e <= req_t + 45);
      x_done   = has_req && kind == 0 && fs_t >= 0 && e == fs_t;
      x_resetn = !(has_req && kind == 0 && fs_t >= 0 && e >= fs_t && e <= fs_t + G);
      if (has_req && kind == 0 && fs_t >= 0 && e == fs_t + 1) begin
         x_hin = p_hin; x_vin = p_vin; x_hout = p_hout; x_vout = p_vout;
         x_sfh = p_sfh; x_sfv = p_sfv;
      end
      if (has_req && kind == 1 && e == req_t + 1) x_err = 1;
      if (has_req && kind == 2 && e == req_t + 46) x_err = 1;
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (model_valid) begin
         chk("busy",   32'(busy),   32'(x_busy));
         chk("done",   32'(done),   32'(x_done));
         chk("resetn", 32'(resetn), 32'(x_resetn));
         chk("err",    32'(err),    32'(x_err));
         chk("hin",    32'(o_hin),  x_hin);
         chk("vin",    32'(o_vin),  x_vin);
         chk("hout",   32'(o_hout), x_hout);
         chk("vout",   32'(o_vout), x_vout);
         chk("sfh",    32'(o_sfh),  x_sfh);
         chk("sfv",    32'(o_sfv),  x_sfv);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      we = 0; fs = 0; rst = 0;
   endtask

   function automatic logic [12:0] pick();
      case ($urandom_range(0, 7))
         0:       return 13'd0;
         1:       return 13'd1;
         2:       return 13'd8191;
         3:       return 13'($urandom_range(2, 64));
         default: return 13'($urandom_range(0, 8191));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      rst = 1; we = 0; fs = 0; hin = 0; vin = 0; hout = 0; vout = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      tick();
      chk("rst_resetn", 32'(resetn), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_hin", 32'(o_hin), 960);
      chk("rst_sfh", 32'(o_sfh), 767);
      chk("rst_sfv", 32'(o_sfv), 766);

      // 1920x1080 -> 1280x720, with an ignored second request and early frame pulses
      hin = 1920; vin = 1080; hout = 1280; vout = 720; we = 1;
      tick();
      low = 0;
      for (int k = 1; k <= 90; k++) begin
         if (k == 10) begin hin = 640; vin = 480; hout = 320; vout = 240; we = 1; end
         if (k == 30 || k == 40 || k == 46 || k == 60) fs = 1;
         tick();
         if (!resetn) low++;
         if (k == 59) chk("no_done_before", 32'(done), 0);
         if (k == 60) begin
            chk("done_at_swap", 32'(done), 1);
            chk("hin_unchanged", 32'(o_hin), 960);
         end
         if (k == 61) begin
            chk("sfh_1920", 32'(o_sfh), 1535);
            chk("sfv_1080", 32'(o_sfv), 1534);
            chk("hin_1920", 32'(o_hin), 1920);
         end
      end
      chk("resetn_low_len", low, 17);
      chk("busy_after_swap", 32'(busy), 0);

      // Saturating request
      hin = 8191; vin = 8191; hout = 1; vout = 1; we = 1;
      tick();
      low = 0;
      for (int k = 1; k <= 90; k++) begin
         if (k == 50) fs = 1;
         tick();
         if (!resetn) low++;
      end
`ifdef SCALER_CFG_VALIDATE_EN
      chk("sat_err", 32'(err), 1);
      chk("sat_sfh_kept", 32'(o_sfh), 1535);
      chk("sat_no_reset", low, 0);
`else
      chk("sat_sfh", 32'(o_sfh), 65535);
      chk("sat_sfv", 32'(o_sfv), 65535);
      chk("sat_reset_len", low, 17);
`endif

      // Reset while pending
      hin = 800; vin = 600; hout = 400; vout = 300; we = 1;
      tick();
      repeat (55) tick();
      chk("pend_busy", 32'(busy), 1);
      rst = 1;
      tick();
      chk("pend_rst_hin", 32'(o_hin), 960);
      chk("pend_rst_sfh", 32'(o_sfh), 767);
      chk("pend_rst_busy", 32'(busy), 0);
      fs = 1;
      tick();
      repeat (30) tick();
      chk("pend_lost_sfv", 32'(o_sfv), 766);

      // Randomized traffic
      for (int c = 0; c < 6000; c++) begin
         rst = ($urandom_range(0, 999) == 0);
         we  = ($urandom_range(0, 19) == 0);
         fs  = ($urandom_range(0, 24) == 0);
         if (we) begin
            hin = pick(); vin = pick(); hout = pick(); vout = pick();
         end
         @(posedge clk);
         #1;
      end
      tick();
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
